// File: rtl/idex_ecc_pkg.sv
// Shared constants and types for the ID/EX SECDED checker.
package idex_ecc_pkg;

    localparam int DATA_W     = 32;
    localparam int CODE_W     = 39;
    localparam int NUM_PAR    = 6;
    localparam int NUM_FIELDS = 5;

    // Hamming parity positions inside code bits [38:1]
    localparam int PAR_POS [NUM_PAR] = '{1, 2, 4, 8, 16, 32};

    // Field indices; also the bit order of ce_flags / ue_flags
    localparam int FLD_RD1 = 0;
    localparam int FLD_RD2 = 1;
    localparam int FLD_IMM = 2;
    localparam int FLD_PC  = 3;
    localparam int FLD_PC4 = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REPLAY = 2'd1,
        ST_FATAL  = 2'd2
    } state_t;

    // True when a Hamming position carries a parity bit rather than data
    function automatic logic is_parity_pos(input int pos);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_PAR; i++)
            if (PAR_POS[i] == pos) r = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/secded39_decode.sv
// Combinational SECDED decoder for one 39-bit word (32 data bits).
module secded39_decode
    import idex_ecc_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic              ce,
    output logic              ue,
    output logic [5:0]        syndrome
);

    logic              p;
    logic              s_in_range;
    logic [CODE_W-1:1] fixed;

    // Syndrome: XOR of the position numbers of every set bit in [38:1]
    always_comb begin
        syndrome = '0;
        for (int k = 1; k < CODE_W; k++)
            if (code[k]) syndrome = syndrome ^ 6'(k);
    end

    assign p          = ^code;
    assign s_in_range = (syndrome <= 6'(CODE_W - 1));
    // s == 0 with p == 1 is a bit-0 error: still correctable, nothing to flip
    assign ce         = p & s_in_range;
    assign ue         = (~p & (syndrome != 6'd0)) | (p & ~s_in_range);

    // Flip the addressed position only when correctable; UE passes raw bits
    always_comb begin
        for (int k = 1; k < CODE_W; k++)
            fixed[k] = code[k] ^ (ce && (syndrome == 6'(k)));
    end

    // Gather data bits from the non-parity positions in ascending order
    always_comb begin
        int j;
        j    = 0;
        data = '0;
        for (int k = 1; k < CODE_W; k++) begin
            if (!is_parity_pos(k)) begin
                data[j] = fixed[k];
                j++;
            end
        end
    end

endmodule

// File: rtl/idex_ecc_checker.sv
// Execute-side ID/EX checker: corrects five SECDED fields, registers the
// results, counts CE/UE beats and runs the replay/fatal FSM.
module idex_ecc_checker
    import idex_ecc_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [38:0]      RD1_E_ECC,
    input  logic [38:0]      RD2_E_ECC,
    input  logic [38:0]      Imm_Ext_E_ECC,
    input  logic [38:0]      PCE_ECC,
    input  logic [38:0]      PCPlus4E_ECC,
    input  logic             clr_cnt,
    output logic             valid_out,
    output logic [31:0]      RD1_E,
    output logic [31:0]      RD2_E,
    output logic [31:0]      Imm_Ext_E,
    output logic [31:0]      PCE,
    output logic [31:0]      PCPlus4E,
    output logic [4:0]       ce_flags,
    output logic [4:0]       ue_flags,
    output logic             replay_req,
    output logic             fatal,
    output logic [CNT_W-1:0] ce_cnt,
    output logic [CNT_W-1:0] ue_cnt
);

    localparam logic [3:0]       MAX_R   = 4'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CODE_W-1:0]     code_in [NUM_FIELDS];
    logic [DATA_W-1:0]     dec_data [NUM_FIELDS];
    logic [5:0]            dec_syn_unused [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] dec_ce, dec_ue;

    assign code_in[FLD_RD1] = RD1_E_ECC;
    assign code_in[FLD_RD2] = RD2_E_ECC;
    assign code_in[FLD_IMM] = Imm_Ext_E_ECC;
    assign code_in[FLD_PC]  = PCE_ECC;
    assign code_in[FLD_PC4] = PCPlus4E_ECC;

    // Syndromes are brought out of the decoders for debug probing only
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_dec
        secded39_decode u_dec (
            .code     (code_in[f]),
            .data     (dec_data[f]),
            .ce       (dec_ce[f]),
            .ue       (dec_ue[f]),
            .syndrome (dec_syn_unused[f])
        );
    end

    logic       any_ce, any_ue;
    state_t     state_q, state_d;
    logic [3:0] retry_q, retry_d;
    logic       valid_d, replay_d, ce_inc, ue_inc;
    logic [4:0] ce_d, ue_d;

    assign any_ce = |dec_ce;
    assign any_ue = |dec_ue;

    // Next state, retry tracking and next registered outputs
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        valid_d  = 1'b0;
        replay_d = 1'b0;
        ce_d     = '0;
        ue_d     = '0;
        ce_inc   = 1'b0;
        ue_inc   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (valid_in) begin
                    ce_d = dec_ce;
                    ue_d = dec_ue;
                    if (any_ue) begin
                        // UE dominates: no CE count, beat is dropped
                        ue_inc = 1'b1;
                        if (retry_q + 4'd1 == MAX_R) begin
                            state_d = ST_FATAL;
                        end else begin
                            retry_d  = retry_q + 4'd1;
                            replay_d = 1'b1;
                            state_d  = ST_REPLAY;
                        end
                    end else begin
                        valid_d = 1'b1;
                        retry_d = '0;
                        ce_inc  = any_ce;
                    end
                end
            end
            ST_REPLAY: state_d = ST_RUN;   // flush window, input ignored
            ST_FATAL:  state_d = ST_FATAL; // only rst leaves
            default:   state_d = ST_RUN;
        endcase
    end

    // FSM state, retry count and control/flag outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            retry_q    <= '0;
            valid_out  <= 1'b0;
            replay_req <= 1'b0;
            fatal      <= 1'b0;
            ce_flags   <= '0;
            ue_flags   <= '0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            valid_out  <= valid_d;
            replay_req <= replay_d;
            fatal      <= (state_d == ST_FATAL);
            ce_flags   <= ce_d;
            ue_flags   <= ue_d;
        end
    end

    // Corrected data only updates on an accepted beat, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RD1_E     <= '0;
            RD2_E     <= '0;
            Imm_Ext_E <= '0;
            PCE       <= '0;
            PCPlus4E  <= '0;
        end else if (valid_d) begin
            RD1_E     <= dec_data[FLD_RD1];
            RD2_E     <= dec_data[FLD_RD2];
            Imm_Ext_E <= dec_data[FLD_IMM];
            PCE       <= dec_data[FLD_PC];
            PCPlus4E  <= dec_data[FLD_PC4];
        end
    end

    // Saturating error counters; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_cnt <= '0;
            ue_cnt <= '0;
        end else if (clr_cnt) begin
            ce_cnt <= '0;
            ue_cnt <= '0;
        end else begin
            if (ce_inc && ce_cnt != CNT_MAX) ce_cnt <= ce_cnt + 1'b1;
            if (ue_inc && ue_cnt != CNT_MAX) ue_cnt <= ue_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_idex_ecc_checker.sv
// Self-checking bench for idex_ecc_checker: directed scenarios plus a
// randomized run against a beat-level behavioural model.
module tb_idex_ecc_checker;

    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0, clr_cnt = 1'b0;
    logic [38:0] RD1_E_ECC = '0, RD2_E_ECC = '0, Imm_Ext_E_ECC = '0, PCE_ECC = '0, PCPlus4E_ECC = '0;
    logic        valid_out, replay_req, fatal;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  ce_flags, ue_flags;
    logic [7:0]  ce_cnt, ue_cnt;

    idex_ecc_checker #(.CNT_W(8), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .RD1_E_ECC(RD1_E_ECC), .RD2_E_ECC(RD2_E_ECC), .Imm_Ext_E_ECC(Imm_Ext_E_ECC),
        .PCE_ECC(PCE_ECC), .PCPlus4E_ECC(PCPlus4E_ECC), .clr_cnt(clr_cnt),
        .valid_out(valid_out), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ce_flags(ce_flags), .ue_flags(ue_flags),
        .replay_req(replay_req), .fatal(fatal), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stimulus fields: intended data, injected code word, number of flips
    logic [31:0] fdata [5];
    logic [38:0] fcode [5];
    int          nflip [5];

    // Model state: 0 = running, 1 = flush cycle, 2 = dead until reset
    int          m_mode;
    int          m_retry;
    logic [7:0]  m_ce, m_ue;
    logic        e_valid, e_replay, e_fatal;
    logic [4:0]  e_ce, e_ue;
    logic [31:0] e_d [5];

    logic [188:0] got_all, exp_all;
    assign got_all = {valid_out, replay_req, fatal, ce_flags, ue_flags, ce_cnt, ue_cnt,
                      RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E};
    assign exp_all = {e_valid, e_replay, e_fatal, e_ce, e_ue, m_ce, m_ue,
                      e_d[0], e_d[1], e_d[2], e_d[3], e_d[4]};

    // Build a code word straight from the layout: data in non-power-of-two
    // positions, parity bits chosen so the syndrome is zero, bit 0 even parity
    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] c;
        logic [5:0]  s;
        int          j;
        c = '0; s = '0; j = 0;
        for (int k = 1; k < 39; k++) begin
            if ((k & (k - 1)) != 0) begin
                c[k] = d[j];
                if (d[j]) s = s ^ 6'(k);
                j++;
            end
        end
        for (int i = 0; i < 6; i++) c[1 << i] = s[i];
        c[0] = ^c[38:1];
        return c;
    endfunction

    task automatic set_field(input int f, input logic [31:0] d, input int b0, input int b1);
        logic [38:0] c;
        c = encode(d);
        nflip[f] = 0;
        if (b0 >= 0) begin c[b0] = ~c[b0]; nflip[f]++; end
        if (b1 >= 0) begin c[b1] = ~c[b1]; nflip[f]++; end
        fdata[f] = d;
        fcode[f] = c;
    endtask

    task automatic set_clean(input logic [31:0] r1, r2, im, pc, pc4);
        set_field(0, r1, -1, -1);
        set_field(1, r2, -1, -1);
        set_field(2, im, -1, -1);
        set_field(3, pc, -1, -1);
        set_field(4, pc4, -1, -1);
    endtask

    task automatic model_reset();
        m_mode = 0; m_retry = 0; m_ce = '0; m_ue = '0;
        e_valid = 0; e_replay = 0; e_fatal = 0; e_ce = '0; e_ue = '0;
        for (int f = 0; f < 5; f++) e_d[f] = '0;
    endtask

    // One beat of the reference behaviour: one flip = corrected, two = UE
    task automatic model_beat(input logic v, input logic clr);
        logic any_ue, any_ce;
        e_valid = 0; e_replay = 0; e_ce = '0; e_ue = '0;
        if (m_mode == 2) begin
            e_fatal = 1;
        end else if (m_mode == 1) begin
            m_mode = 0;
        end else if (v) begin
            any_ue = 0; any_ce = 0;
            for (int f = 0; f < 5; f++) begin
                e_ce[f] = (nflip[f] == 1);
                e_ue[f] = (nflip[f] == 2);
                any_ce |= e_ce[f];
                any_ue |= e_ue[f];
            end
            if (any_ue) begin
                if (m_ue != 8'd255) m_ue++;
                if (m_retry + 1 == MAXR) begin
                    m_mode = 2; e_fatal = 1;
                end else begin
                    m_retry++; m_mode = 1; e_replay = 1;
                end
            end else begin
                e_valid = 1; m_retry = 0;
                for (int f = 0; f < 5; f++) e_d[f] = fdata[f];
                if (any_ce && m_ce != 8'd255) m_ce++;
            end
        end
        if (clr) begin m_ce = '0; m_ue = '0; end
    endtask

    task automatic step(input logic v, input logic clr);
        @(negedge clk);
        valid_in = v; clr_cnt = clr;
        RD1_E_ECC = fcode[0]; RD2_E_ECC = fcode[1]; Imm_Ext_E_ECC = fcode[2];
        PCE_ECC = fcode[3]; PCPlus4E_ECC = fcode[4];
        model_beat(v, clr);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; valid_in = 0; clr_cnt = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (got_all !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", got_all);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_clean();
        set_clean(32'hDEADBEEF, 32'h1, 32'hFFFFF800, 32'h100, 32'h104);
        step(1, 0);
        checks++;
        if (got_all !== exp_all) begin
            errors++; $display("FAIL clean_model got=%h exp=%h", got_all, exp_all);
        end
        checks++;
        if ({valid_out, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ce_flags, ue_flags, ce_cnt, ue_cnt}
            !== {1'b1, 32'hDEADBEEF, 32'h1, 32'hFFFFF800, 32'h100, 32'h104, 5'd0, 5'd0, 8'd0, 8'd0}) begin
            errors++; $display("FAIL clean_exact got=%h %h %h %h %h %h", valid_out, RD1_E, RD2_E,
                               Imm_Ext_E, PCE, PCPlus4E);
        end
    endtask

    task automatic test_single();
        set_field(1, 32'h1, 17, -1);
        step(1, 0);
        checks++;
        if (got_all !== exp_all) begin
            errors++; $display("FAIL single_model got=%h exp=%h", got_all, exp_all);
        end
        checks++;
        if ({valid_out, RD2_E, ce_flags, ue_flags, ce_cnt} !== {1'b1, 32'h1, 5'b00010, 5'b0, 8'd1}) begin
            errors++; $display("FAIL single_exact v=%b rd2=%h ce=%b ue=%b cnt=%0d", valid_out, RD2_E,
                               ce_flags, ue_flags, ce_cnt);
        end
    endtask

    task automatic test_double();
        set_clean(32'h11111111, 32'h22222222, 32'h33333333, 32'h200, 32'h204);
        set_field(2, 32'h33333333, 5, 20);
        step(1, 0);
        checks++;
        if ({valid_out, replay_req, ue_flags, ue_cnt, RD1_E} !== {1'b0, 1'b1, 5'b00100, 8'd1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL double_ue v=%b rr=%b ue=%b cnt=%0d rd1=%h", valid_out, replay_req,
                               ue_flags, ue_cnt, RD1_E);
        end
        set_clean(32'h44444444, 32'h5, 32'h6, 32'h300, 32'h304);
        step(1, 0);   // lands in the flush cycle and must be dropped
        checks++;
        if ({valid_out, replay_req} !== 2'b00 || got_all !== exp_all) begin
            errors++; $display("FAIL replay_drop got=%h exp=%h", got_all, exp_all);
        end
        step(1, 0);
        checks++;
        if (valid_out !== 1'b1 || RD1_E !== 32'h44444444 || got_all !== exp_all) begin
            errors++; $display("FAIL after_replay got=%h exp=%h", got_all, exp_all);
        end
    endtask

    task automatic test_fatal();
        step(0, 1);
        for (int n = 0; n < 3; n++) begin
            set_clean(32'h7, 32'h8, 32'h9, 32'h400, 32'h404);
            set_field(0, 32'h7, 3 + n, 30);
            step(1, 0);
            if (n < 2) step(0, 0);
        end
        checks++;
        if ({fatal, valid_out, ue_cnt} !== {1'b1, 1'b0, 8'd3} || got_all !== exp_all) begin
            errors++; $display("FAIL fatal_set fatal=%b v=%b ue_cnt=%0d got=%h exp=%h", fatal,
                               valid_out, ue_cnt, got_all, exp_all);
        end
        set_clean(32'hA, 32'hB, 32'hC, 32'h500, 32'h504);
        step(1, 0);
        checks++;
        if ({fatal, valid_out, replay_req} !== 3'b100) begin
            errors++; $display("FAIL fatal_hold fatal=%b v=%b rr=%b", fatal, valid_out, replay_req);
        end
        do_reset();
        checks++;
        if (fatal !== 1'b0) begin
            errors++; $display("FAIL fatal_reset fatal=%b exp=0", fatal);
        end
        step(1, 0);
        checks++;
        if (valid_out !== 1'b1 || PCE !== 32'h500 || got_all !== exp_all) begin
            errors++; $display("FAIL post_reset got=%h exp=%h", got_all, exp_all);
        end
    endtask

    task automatic test_saturate();
        int guard;
        guard = 0;
        while (m_ce != 8'd255 && guard < 400) begin
            set_clean($urandom, $urandom, $urandom, $urandom, $urandom);
            set_field(int'($urandom_range(0, 4)), $urandom, int'($urandom_range(0, 38)), -1);
            step(1, 0);
            guard++;
        end
        set_field(3, 32'h600, 9, -1);
        step(1, 0);
        checks++;
        if (ce_cnt !== 8'd255 || got_all !== exp_all) begin
            errors++; $display("FAIL ce_saturate cnt=%0d exp=255", ce_cnt);
        end
        set_field(4, 32'h604, 0, -1);
        step(1, 1);
        checks++;
        if (ce_cnt !== 8'd0 || valid_out !== 1'b1 || got_all !== exp_all) begin
            errors++; $display("FAIL clr_wins cnt=%0d v=%b exp cnt=0", ce_cnt, valid_out);
        end
    endtask

    task automatic test_mixed();
        set_clean(32'hCAFEF00D, 32'h2, 32'h3, 32'h700, 32'h704);
        set_field(3, 32'h700, 0, -1);
        set_field(0, 32'hCAFEF00D, 12, 33);
        step(1, 0);
        checks++;
        if ({ce_flags, ue_flags, ue_cnt, ce_cnt, valid_out} !== {5'b01000, 5'b00001, 8'd1, 8'd0, 1'b0}) begin
            errors++; $display("FAIL mixed ce=%b ue=%b ue_cnt=%0d ce_cnt=%0d v=%b", ce_flags, ue_flags,
                               ue_cnt, ce_cnt, valid_out);
        end
        step(0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 600; it++) begin
            for (int f = 0; f < 5; f++) begin
                int r, b0, b1;
                r  = int'($urandom_range(0, 24));
                b0 = int'($urandom_range(0, 38));
                b1 = (b0 + 1 + int'($urandom_range(0, 37))) % 39;
                if (r == 0)     set_field(f, $urandom, b0, b1);
                else if (r < 4) set_field(f, $urandom, b0, -1);
                else            set_field(f, $urandom, -1, -1);
            end
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
            checks++;
            if (got_all !== exp_all) begin
                errors++; $display("FAIL random_%0d got=%h exp=%h", it, got_all, exp_all);
            end
            if (m_mode == 2 && $urandom_range(0, 2) == 0) do_reset();
        end
    endtask

    initial begin
        model_reset();
        for (int f = 0; f < 5; f++) begin fdata[f] = '0; fcode[f] = '0; nflip[f] = 0; end
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_fatal();
        test_saturate();
        test_mixed();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
